serial_parity_checker: RTL and testbench
========================================

Name: serial_parity_checker

Overview:
Receive-side partner of the XOR parity generator. Accepts a serial frame of DATA_W data bits followed by one parity bit, delivered LSB-first under a bit_valid qualifier, and reassembles the data word. Recomputes parity over the data bits with a running XOR and flags a mismatch. Sits at the far end of the serial parity link and returns parallel words plus an error flag to downstream logic.

Parameters:
DATA_W, 3, number of data bits per frame (range 1..32)
ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected
TIMEOUT, 16, idle cycles allowed between valid bits mid-frame; used only when FRAME_TIMEOUT_EN is defined

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  frame start marker, sampled only in IDLE
bit_valid  input  1  bit_in is valid this cycle
bit_in  input  1  serial data/parity bit
busy  output  1  high while a frame is in progress (DATA or PARITY)
done  output  1  one-cycle pulse, frame complete
data_out  output  DATA_W  last received data word, bit 0 = first bit received
parity_err  output  1  parity result of last frame, 1 = mismatch
timeout  output  1  one-cycle abort pulse; port present only with FRAME_TIMEOUT_EN

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, bit counter=0, shift register=0, running parity=0, busy=0, done=0, data_out=0, parity_err=0, timeout=0. Reset mid-frame discards the partial frame with no done pulse.
- FSM states: IDLE, DATA, PARITY.
- IDLE: start=1 -> DATA; counter, shift register and running parity cleared. bit_valid in the same cycle as start is ignored (start has priority; that bit is not captured). bit_valid without start is ignored.
- DATA: each cycle with bit_valid=1, bit_in is placed at position counter of the shift register, running parity ^= bit_in, counter++. When the DATA_W-th bit is accepted -> PARITY. Cycles with bit_valid=0 hold all state (gaps are legal).
- PARITY: first cycle with bit_valid=1 -> IDLE; at that same edge data_out <= shift register, parity_err <= running ^ bit_in ^ ODD_PARITY, done <= 1.
- done is high for exactly the one cycle after the parity bit is accepted (latency 1). data_out and parity_err then hold until the next done or reset.
- start during DATA or PARITY is ignored; it neither restarts nor aborts the frame.
- start in the cycle done is high (state IDLE) is accepted, so back-to-back frames are supported with zero dead cycles.
- busy = (state != IDLE), combinationally decoded from the registered state.
- Counter width is clog2(DATA_W+1). It never wraps because it is cleared on every start.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined: an idle counter increments on every DATA/PARITY cycle with bit_valid=0 and clears on bit_valid=1 or on start. When it reaches TIMEOUT, the FSM returns to IDLE, timeout pulses high for one cycle, done stays 0, and data_out/parity_err keep their previous values. rst clears the idle counter and timeout.
- Not defined: no idle counter, no timeout port, and a frame may stall indefinitely.

Test Plan:
- DATA_W=3, even: start, then bits 1,0,1, parity 0 -> done pulse 1 cycle after the parity bit, data_out=3'b101, parity_err=0.
- Exhaustive sweep of all 8 data words 000..111 with correct even parity (XOR of the 3 bits), sent back-to-back with start asserted during done -> 8 done pulses, each data_out matching its word, parity_err=0 every time.
- Data 1,1,0 with parity 1 (wrong) -> data_out=3'b011, parity_err=1. Repeat with ODD_PARITY=1 and parity 1 -> parity_err=0.
- Bits separated by 0-3 cycle gaps of bit_valid=0, plus start pulses injected mid-frame -> result identical to the gapless frame, busy stays high throughout, no restart.
- rst asserted after 2 data bits, then a full frame 0,1,1 parity 0 -> no done pulse from the aborted frame; second frame gives data_out=3'b110, parity_err=0; all outputs 0 during reset.
- With FRAME_TIMEOUT_EN defined and TIMEOUT=16: start, 1 bit, then 16 idle cycles -> timeout pulses once, busy=0, done=0, data_out unchanged. A following normal frame completes correctly.

Source files
------------

// File: rtl/serial_parity_checker.sv
// Serial parity checker: takes LSB-first data bits and then one parity bit, and returns the word with a mismatch flag.
// Optional mid-frame stall abort when FRAME_TIMEOUT_EN is defined (adds TIMEOUT parameter and timeout port).
module serial_parity_checker #(
  parameter int DATA_W     = 3,
  parameter int ODD_PARITY = 0
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err
`ifdef FRAME_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam logic             ODD_BIT  = (ODD_PARITY != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_s;
  logic              run_par_r;
  logic              run_par_s;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_s;
  logic              perr_r;
  logic              perr_s;
  logic              done_r;
  logic              done_s;

  function automatic logic parity_accumulate(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  // The received parity bit closes the XOR chain; the result is 1 when it disagrees with the expected sense.
  function automatic logic parity_mismatch(input logic acc, input logic pbit);
    return acc ^ pbit ^ ODD_BIT;
  endfunction

  function automatic logic [DATA_W-1:0] place_bit(
    input logic [DATA_W-1:0] word,
    input logic [CNT_W-1:0]  idx,
    input logic              b
  );
    logic [DATA_W-1:0] res;
    res = word;
    for (int i = 0; i < DATA_W; i++) begin
      if (idx == CNT_W'(i)) begin
        res[i] = b;
      end else begin
        res[i] = word[i];
      end
    end
    return res;
  endfunction

`ifdef FRAME_TIMEOUT_EN
  localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_r;
  logic [IDLE_W-1:0] idle_s;
  logic              timeout_r;
  logic              timeout_s;
`endif

  // Next-state and datapath decode for the frame receiver.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    shift_s   = shift_r;
    run_par_s = run_par_r;
    data_s    = data_r;
    perr_s    = perr_r;
    done_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_DATA;
          cnt_s     = {CNT_W{1'b0}};
          shift_s   = {DATA_W{1'b0}};
          run_par_s = 1'b0;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bit_valid) begin
          shift_s   = place_bit(shift_r, cnt_r, bit_in);
          run_par_s = parity_accumulate(run_par_r, bit_in);
          cnt_s     = cnt_r + CNT_W'(1);
          if (cnt_r == LAST_IDX) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_valid) begin
          state_s = ST_IDLE;
          data_s  = shift_r;
          perr_s  = parity_mismatch(run_par_r, bit_in);
          done_s  = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

`ifdef FRAME_TIMEOUT_EN
    timeout_s = 1'b0;
    // A stalled frame is dropped without touching the last good result.
    if ((state_r != ST_IDLE) && !bit_valid && !start) begin
      if (idle_r == IDLE_LAST) begin
        idle_s    = {IDLE_W{1'b0}};
        timeout_s = 1'b1;
        state_s   = ST_IDLE;
      end else begin
        idle_s    = idle_r + IDLE_W'(1);
      end
    end else begin
      idle_s = {IDLE_W{1'b0}};
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      run_par_r <= 1'b0;
      data_r    <= {DATA_W{1'b0}};
      perr_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      idle_r    <= {IDLE_W{1'b0}};
      timeout_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      shift_r   <= shift_s;
      run_par_r <= run_par_s;
      data_r    <= data_s;
      perr_r    <= perr_s;
      done_r    <= done_s;
`ifdef FRAME_TIMEOUT_EN
      idle_r    <= idle_s;
      timeout_r <= timeout_s;
`endif
    end
  end

  assign busy       = (state_r != ST_IDLE);
  assign done       = done_r;
  assign data_out   = data_r;
  assign parity_err = perr_r;
`ifdef FRAME_TIMEOUT_EN
  assign timeout    = timeout_r;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances share one stimulus stream,
// checked each cycle against a frame-level reference model.
module tb_serial_parity_checker;

  localparam int DW = 3;
`ifdef FRAME_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic clk = 1'b0;
  logic rst, start, bit_valid, bit_in;
  logic busy_e, done_e, perr_e, busy_o, done_o, perr_o;
  logic [DW-1:0] data_e, data_o;
`ifdef FRAME_TIMEOUT_EN
  logic to_e, to_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy;
  int          m_cnt;
  logic [DW-1:0] m_word, m_data;
  logic        m_done, m_err_e, m_err_o, m_to;
  int          m_idle;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(0)
`ifdef FRAME_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut_even (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy_e), .done(done_e), .data_out(data_e), .parity_err(perr_e)
`ifdef FRAME_TIMEOUT_EN
    , .timeout(to_e)
`endif
  );

  serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(1)
`ifdef FRAME_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut_odd (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy_o), .done(done_o), .data_out(data_o), .parity_err(perr_o)
`ifdef FRAME_TIMEOUT_EN
    , .timeout(to_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: collect DW bits, then judge parity by counting ones.
  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0; m_cnt = 0; m_word = '0; m_data = '0;
      m_done = 1'b0; m_err_e = 1'b0; m_err_o = 1'b0; m_to = 1'b0; m_idle = 0;
    end else begin
      m_done = 1'b0;
      m_to   = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_cnt = 0; m_word = '0; m_idle = 0;
        end
      end else if (bit_valid) begin
        m_idle = 0;
        if (m_cnt < DW) begin
          m_word[m_cnt] = bit_in;
          m_cnt++;
        end else begin
          m_busy  = 1'b0;
          m_data  = m_word;
          m_err_e = ((($countones(m_word) + int'(bit_in)) % 2) == 1);
          m_err_o = ((($countones(m_word) + int'(bit_in) + 1) % 2) == 1);
          m_done  = 1'b1;
        end
      end else begin
`ifdef FRAME_TIMEOUT_EN
        if (start) begin
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_busy = 1'b0; m_to = 1'b1; m_idle = 0;
          end
        end
`endif
      end
    end
  endtask

  task automatic compare_all();
    check("busy_even", busy_e, m_busy);
    check("done_even", done_e, m_done);
    check("data_even", data_e, m_data);
    check("perr_even", perr_e, m_err_e);
    check("busy_odd",  busy_o, m_busy);
    check("done_odd",  done_o, m_done);
    check("data_odd",  data_o, m_data);
    check("perr_odd",  perr_o, m_err_o);
`ifdef FRAME_TIMEOUT_EN
    check("timeout_even", to_e, m_to);
    check("timeout_odd",  to_o, m_to);
`endif
  endtask

  task automatic cyc(input logic s, input logic v, input logic b);
    start = s; bit_valid = v; bit_in = b;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Start cycle, DW data bits, parity bit; optional random gaps and stray start pulses.
  task automatic send_frame(input logic [DW-1:0] word, input logic pbit, input int maxgap, input bit inj);
    cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i <= DW; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int g = 0; g < gap; g++) begin
        cyc(inj ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
      cyc(inj ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, (i < DW) ? word[i] : pbit);
    end
  endtask

  task automatic frame_result(input string tag, input logic [DW-1:0] w, input logic ee, input logic eo);
    check({tag, "_done"}, {done_e, done_o}, 2'b11);
    check({tag, "_data_e"}, data_e, w);
    check({tag, "_data_o"}, data_o, w);
    check({tag, "_perr_e"}, perr_e, ee);
    check({tag, "_perr_o"}, perr_o, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    logic p, ee;
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("reset_outputs", {busy_e, done_e, data_e, perr_e}, '0);
    rst = 1'b0;

    // Idle traffic without start is ignored
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    check("idle_ignore_busy", busy_e, 1'b0);

    // Bits 1,0,1 parity 0
    send_frame(3'b101, 1'b0, 0, 1'b0);
    frame_result("f101", 3'b101, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("done_one_cycle", done_e, 1'b0);
    check("data_hold", data_e, 3'b101);

    // All words back-to-back with correct even parity
    for (int k = 0; k < 8; k++) begin
      w = 3'(k);
      p = 1'(($countones(w)) % 2);
      send_frame(w, p, 0, 1'b0);
      frame_result("sweep", w, 1'b0, 1'b1);
    end

    // Bits 1,1,0 with wrong even parity
    send_frame(3'b011, 1'b1, 0, 1'b0);
    frame_result("f011", 3'b011, 1'b1, 1'b0);

    // Random words with gaps and stray start pulses mid-frame
    for (int k = 0; k < 20; k++) begin
      w  = 3'($urandom_range(0, 7));
      p  = 1'($urandom_range(0, 1));
      ee = 1'(($countones(w) + int'(p)) % 2);
      send_frame(w, p, 3, 1'b1);
      frame_result("rand", w, ee, ~ee);
      cyc(1'b0, 1'b0, 1'b0);
    end

    // Reset after two data bits, then 0,1,1 parity 0
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    check("midreset_outputs", {busy_e, done_e, data_e, perr_e}, '0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    check("after_reset_nodone", done_e, 1'b0);
    send_frame(3'b110, 1'b0, 0, 1'b0);
    frame_result("f110", 3'b110, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

`ifdef FRAME_TIMEOUT_EN
    // One data bit then a stall long enough to abort
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < TO; k++) cyc(1'b0, 1'b0, 1'b0);
    check("to_pulse", {to_e, busy_e, done_e}, 3'b100);
    check("to_data_kept", data_e, 3'b110);
    cyc(1'b0, 1'b0, 1'b0);
    check("to_one_cycle", to_e, 1'b0);
    send_frame(3'b010, 1'b1, 0, 1'b0);
    frame_result("after_to", 3'b010, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
